// File: rtl/vec_dot_accum.sv
// Pipelined unsigned dot-product accumulator: captures a*b per element index,
// sums over one vector and hands the result out through a one-entry buffer.
module vec_dot_accum #(
    parameter int unsigned LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  count,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [19:0] result,
    output logic        seq_err,
    output logic        overrun
);

    localparam logic [3:0] LastIdx = 4'(LEN - 1);

    logic        en_q;
    logic        v1_q, v1_d;
    logic [15:0] p1_q, p1_d;
    logic [3:0]  i1_q, i1_d;
    logic [3:0]  exp_q, exp_d;
    logic [19:0] acc_q, acc_d;
    logic        valid_q, valid_d;
    logic [19:0] result_q, result_d;
    logic        seq_err_q, seq_err_d;
    logic        overrun_q, overrun_d;

    logic        idx_ok;
    logic        last;
    logic        offer;
    logic [19:0] sum;

    // Index 0 always restarts a vector; otherwise only the expected successor is taken.
    always_comb begin
        idx_ok = (32'(count) < LEN) &&
                 ((count == 4'd0) || ((count == exp_q) && (exp_q != 4'd0)));

        v1_d      = 1'b0;
        p1_d      = p1_q;
        i1_d      = i1_q;
        exp_d     = exp_q;
        seq_err_d = seq_err_q;

        if (en_q) begin
            p1_d = 16'(a) * 16'(b);
            i1_d = count;
            if (idx_ok) begin
                v1_d  = 1'b1;
                exp_d = (count == LastIdx) ? 4'd0 : count + 4'd1;
            end else begin
                seq_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        sum   = (i1_q == 4'd0) ? 20'(p1_q) : acc_q + 20'(p1_q);
        last  = (i1_q == LastIdx);
        offer = v1_q && last;

        acc_d = acc_q;
        if (v1_q) begin
            acc_d = last ? 20'd0 : sum;
        end

        valid_d   = valid_q;
        result_d  = result_q;
        overrun_d = overrun_q;
        if (offer) begin
            if (!valid_q || out_ready) begin
                result_d = sum;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            v1_q      <= 1'b0;
            p1_q      <= '0;
            i1_q      <= '0;
            exp_q     <= '0;
            acc_q     <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            seq_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            en_q      <= enable;
            v1_q      <= v1_d;
            p1_q      <= p1_d;
            i1_q      <= i1_d;
            exp_q     <= exp_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            seq_err_q <= seq_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign seq_err   = seq_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_vec_dot_accum.sv
// Self-checking bench: table-driven vectors plus scoreboard queues for a LEN=16
// and a LEN=1 instance, with hand-written backpressure/error/reset sequences.
module tb_vec_dot_accum;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        enable, out_ready, out_valid, seq_err, overrun;
    logic [3:0]  count;
    logic [7:0]  a, b;
    logic [19:0] result;

    logic        enable1, ready1, out_valid1, seq_err1, overrun1;
    logic [3:0]  count1;
    logic [7:0]  a1, b1;
    logic [19:0] result1;

    vec_dot_accum #(.LEN(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .count(count), .a(a), .b(b),
        .out_ready(out_ready), .out_valid(out_valid), .result(result),
        .seq_err(seq_err), .overrun(overrun)
    );

    vec_dot_accum #(.LEN(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable1), .count(count1), .a(a1), .b(b1),
        .out_ready(ready1), .out_valid(out_valid1), .result(result1),
        .seq_err(seq_err1), .overrun(overrun1)
    );

    typedef struct {
        logic [7:0]  a0;
        logic [7:0]  astep;
        logic [7:0]  bv;
        logic [19:0] expect_res;
    } vec_t;

    vec_t        tbl[5];
    logic [19:0] q16[$];
    logic [19:0] q1[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          pops1 = 0;
    int          first1 = 0;
    int          last1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out16: got result %0d, required no output", result);
            end else begin
                check("result16", result, q16.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && ready1) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out1: got result %0d, required no output", result1);
            end else begin
                check("result1", result1, q1.pop_front());
                if (pops1 == 0) first1 = cyc;
                last1 = cyc;
                pops1++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic elem(input logic en_next, input logic [3:0] idx,
                        input logic [7:0] av, input logic [7:0] bv);
        enable = en_next;
        count  = idx;
        a      = av;
        b      = bv;
        tick();
    endtask

    task automatic start();
        enable = 1'b1;
        count  = 4'hF;
        a      = '0;
        b      = '0;
        tick();
    endtask

    task automatic run_vec(input logic [7:0] a0, input logic [7:0] astep,
                           input logic [7:0] bv, input logic keep_en);
        for (int k = 0; k < 16; k++) begin
            elem((k < 15) || keep_en, 4'(k), 8'(a0 + astep * 8'(k)), bv);
        end
        enable = 1'b0;
        count  = 4'hF;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q16.size() != 0 || q1.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(q16.size() + q1.size()), 0);
        repeat (2) tick();
    endtask

    initial begin
        tbl[0] = '{8'd1,   8'd1,  8'd2,   20'd272};
        tbl[1] = '{8'd255, 8'd0,  8'd255, 20'd1040400};
        tbl[2] = '{8'd1,   8'd0,  8'd1,   20'd16};
        tbl[3] = '{8'd0,   8'd16, 8'd3,   20'd5760};
        tbl[4] = '{8'd10,  8'd3,  8'd7,   20'd3640};

        rst = 1'b1;
        enable = 1'b0; count = 4'hF; a = '0; b = '0; out_ready = 1'b1;
        enable1 = 1'b0; count1 = 4'hF; a1 = '0; b1 = '0; ready1 = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_out_valid1", out_valid1, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            q16.push_back(tbl[i].expect_res);
            start();
            run_vec(tbl[i].a0, tbl[i].astep, tbl[i].bv, 1'b0);
            if (i == 0) begin
                check("latency_early", out_valid, 0);
                tick();
                check("latency_valid", out_valid, 1);
                check("latency_result", result, tbl[i].expect_res);
            end
            drain("drain_table");
        end
        check("table_seq_err", seq_err, 0);
        check("table_overrun", overrun, 0);

        // Backpressure: second vector is dropped while the first is unread.
        out_ready = 1'b0;
        q16.push_back(20'd272);
        start();
        run_vec(8'd1, 8'd1, 8'd2, 1'b1);
        run_vec(8'd1, 8'd0, 8'd1, 1'b0);
        repeat (3) tick();
        check("bp_valid_held", out_valid, 1);
        check("bp_result_held", result, 272);
        check("bp_overrun", overrun, 1);
        out_ready = 1'b1;
        tick();
        tick();
        check("bp_valid_fall", out_valid, 0);
        check("bp_result_kept", result, 272);
        drain("drain_bp");

        // Sequence error: 0, 1, 3 then a clean vector restarting at 0.
        q16.push_back(20'd160);
        start();
        elem(1'b1, 4'd0, 8'd9, 8'd9);
        elem(1'b1, 4'd1, 8'd9, 8'd9);
        elem(1'b1, 4'd3, 8'd9, 8'd9);
        check("seq_err_set", seq_err, 1);
        run_vec(8'd2, 8'd0, 8'd5, 1'b0);
        drain("drain_seq");
        check("seq_err_sticky", seq_err, 1);
        check("overrun_sticky", overrun, 1);

        // Reset after index 7 of a vector.
        start();
        for (int k = 0; k < 8; k++) elem(1'b1, 4'(k), 8'd200, 8'd200);
        rst = 1'b1;
        enable = 1'b0;
        count = 4'hF;
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_seq_err", seq_err, 0);
        check("midrst_overrun", overrun, 0);
        rst = 1'b0;
        q16.push_back(20'd16);
        start();
        run_vec(8'd1, 8'd0, 8'd1, 1'b0);
        drain("drain_midrst");

        // LEN=1: every index-0 element is a complete vector.
        q1.push_back(20'd12);
        q1.push_back(20'd30);
        q1.push_back(20'd56);
        enable1 = 1'b1; count1 = 4'hF;
        tick();
        count1 = 4'd0; a1 = 8'd3; b1 = 8'd4;
        tick();
        a1 = 8'd5; b1 = 8'd6;
        tick();
        enable1 = 1'b0; a1 = 8'd7; b1 = 8'd8;
        tick();
        count1 = 4'hF;
        drain("drain_len1");
        check("len1_pops", pops1, 3);
        check("len1_consecutive", last1 - first1, 2);
        check("len1_seq_err", seq_err1, 0);
        check("len1_overrun", overrun1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vec_dot_accum.md
# vec_dot_accum

Pipelined unsigned dot-product accumulator that sits directly downstream of the 4-bit enable counter in the 8x8 piped vector multiplier. The counter's `count` is the element index. This block multiplies the 8-bit operand pairs presented against each index and sums them over one vector. It then hands the finished sum to the next stage through a one-entry valid/ready output buffer. It also flags index-sequence errors and dropped results.

## Interface
- `LEN`, default 16: elements per vector, legal range 1..16; last index is `LEN-1`.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  same signal that drives the counter's enable; registered internally.
- `count`  in  4  element index from the counter; `4'hF` while the counter is idle.
- `a`  in  8  unsigned operand, aligned with `count`.
- `b`  in  8  unsigned operand, aligned with `count`.
- `out_ready`  in  1  downstream accepts the result.
- `out_valid`  out  1  result buffer holds an unread result.
- `result`  out  20  dot product, `16+4` bits; cannot overflow for `LEN<=16`.
- `seq_err`  out  1  sticky index-sequence error.
- `overrun`  out  1  sticky dropped-result flag.

## Operation
- **Alignment.**
  - The counter's index lags `enable` by one cycle.
  - `en_q` is `enable` registered, reset 0.
  - A cycle is an element cycle when `en_q=1`; its index is `count` and its operands are `a` and `b`.
- **Stage 1 (capture).**
  - On an element cycle: `p1 <= a*b` (16-bit), `i1 <= count`, `v1 <= 1`.
  - Otherwise `v1 <= 0`.
- **Sequence check (stage 1).** `exp` is the expected next index, reset 0.
  - Index 0 is always accepted and starts a new vector. Any partial sum is discarded without error.
  - An index equal to `exp` with `exp != 0` is accepted.
  - Any other index, or an index `>= LEN`, is rejected: `v1 <= 0` and `seq_err <= 1`.
  - After an accepted index k: `exp <= k+1`, or `exp <= 0` if `k = LEN-1`.
- **Stage 2 (accumulate), when `v1=1`.**
  - `sum = (i1==0) ? p1 : acc + p1`, computed at 20 bits.
  - If `i1 != LEN-1`: `acc <= sum`.
  - If `i1 == LEN-1`: `sum` is offered to the output buffer and `acc <= 0`.
- **Output buffer.**
  - Empty, or `out_ready=1` in the same cycle: `result <= sum`, `out_valid <= 1`.
  - Full and `out_ready=0`: new sum dropped, old result kept, `overrun <= 1`.
  - Handshake completes on `out_valid & out_ready`. With no new sum that cycle, `out_valid <= 0` and `result` holds its value.
  - `result` is stable while `out_valid=1` and `out_ready=0`.
- **`LEN=1`.** Every index-0 element is a complete vector: `sum = p1`.
- **Sticky flags.** `seq_err` and `overrun` clear only on `rst`.

## Timing
- **Reset.** While `rst=1` at posedge, all registers are cleared:
  - `en_q`, `v1`, `p1`, `i1`, `exp`, `acc` = 0.
  - Outputs: `out_valid=0`, `result=0`, `seq_err=0`, `overrun=0`.
- **Reset mid-vector.** Discards the partial sum and any in-flight element; the next accepted vector starts at index 0.
- **Latency.** If the last element's cycle is n, then `out_valid=1` with the final `result` in cycle n+2.
- **Throughput.** One element per cycle; back-to-back vectors with no gap cycles.
- **Enable drop mid-vector.** Element cycles stop and `acc` and `exp` are held. A later resume at `exp` continues the same vector. The counter restarts at 0, so in practice the vector restarts.
- **Simultaneous events.**
  - New sum, buffer full, and `out_ready=1` in the same cycle: new result loaded, no overrun.
  - Index 0 in stage 1 while stage 2 completes the previous vector: both proceed, no interaction.

## Test plan
- **Basic sum.** `LEN=16`, `enable` high for 16 cycles, `a=k+1`, `b=2` per index k -> one `out_valid` pulse 2 cycles after index 15, `result=272`. `seq_err=0`, `overrun=0`.
- **Max value.** `a=b=255` for all 16 elements -> `result=1040400`, no truncation.
- **Output backpressure.**
  - Two back-to-back vectors with `out_ready=0` -> first result held, second dropped, `overrun=1`.
  - Then `out_ready=1` -> `out_valid` falls after one cycle and `result` is still the first sum.
- **Sequence error.** Drive `count` 0, 1, 3 with `en_q=1` -> `seq_err=1`, index 3 dropped. Next index 0 restarts the vector and a clean 16-element vector gives the correct sum.
- **Reset mid-vector.**
  - Assert `rst` for 1 cycle after index 7 -> all outputs 0.
  - Then a full vector `a=1`, `b=1` -> `result=16`, with no contribution from pre-reset elements.
- **Short vector.** `LEN=1`, three elements `(3,4)`, `(5,6)`, `(7,8)` with `out_ready=1` -> results 12, 30, 56 on consecutive cycles.
